// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the trigger-to-pulse generator.
package pulse_gen_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_gen.sv
// Trigger-to-pulse generator: programmable delay, width and holdoff, with
// optional retrigger extension and a strobe for every rejected trigger.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig_in,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  input  logic [CNT_W-1:0] holdoff_cfg,
  input  logic             retrig_en,
  output logic             pulse_out,
  output logic             busy,
  output logic             trig_missed
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // The delay is consumed at acceptance by loading cnt directly, so only
  // width and holdoff need to be held for later phases of the event.
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             missed_c;

  // State, counter, captured config and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      hold_q      <= '0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      trig_missed <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      hold_q      <= hold_d;
      pulse_out   <= (state_d == ST_ACTIVE);
      busy        <= (state_d != ST_IDLE);
      trig_missed <= missed_c;
    end
  end

  // Next-state, counter reload selection and trigger rejection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    width_d  = width_q;
    hold_d   = hold_q;
    missed_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // width_cfg == 0 disables the generator: trigger dropped silently.
        if (trig_in && (width_cfg != '0)) begin
          width_d = width_cfg;
          hold_d  = holdoff_cfg;
          if (delay_cfg == '0) begin
            state_d = ST_ACTIVE;
            cnt_d   = width_cfg - CNT_ONE;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_cfg - CNT_ONE;
          end
        end
      end

      ST_DELAY: begin
        missed_c = trig_in;
        if (cnt_q == '0) begin
          state_d = ST_ACTIVE;
          cnt_d   = width_q - CNT_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_ACTIVE: begin
        // Retrigger wins over the terminal count so the pulse has no gap.
        if (trig_in && retrig_en && (width_cfg != '0)) begin
          cnt_d = width_cfg - CNT_ONE;
        end else begin
          missed_c = trig_in;
          if (cnt_q == '0) begin
            if (hold_q == '0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
              cnt_d   = hold_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      ST_HOLDOFF: begin
        missed_c = trig_in;
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Scoreboard bench for pulse_gen: a timestamp-based reference model predicts
// each cycle's outputs; a monitor compares them against the DUT.
module tb_pulse_gen;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             trig_in;
  logic [CNT_W-1:0] delay_cfg;
  logic [CNT_W-1:0] width_cfg;
  logic [CNT_W-1:0] holdoff_cfg;
  logic             retrig_en;
  logic             pulse_out;
  logic             busy;
  logic             trig_missed;

  pulse_gen #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig_in    (trig_in),
    .delay_cfg  (delay_cfg),
    .width_cfg  (width_cfg),
    .holdoff_cfg(holdoff_cfg),
    .retrig_en  (retrig_en),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .trig_missed(trig_missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic pulse;
    logic busy;
    logic missed;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: the event is described by absolute cycle numbers.
  int m_acc, m_ps, m_pe, m_be, m_h;

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    m_acc = -10; m_ps = -10; m_pe = -10; m_be = -10; m_h = 0;
  endtask

  // Apply one cycle of stimulus, predict the following cycle's outputs.
  task automatic step(input logic t, input int d, input int w, input int h, input logic re);
    int   now;
    logic busy_now, act_now, missed;
    exp_t e;
    trig_in     = t;
    delay_cfg   = CNT_W'(d);
    width_cfg   = CNT_W'(w);
    holdoff_cfg = CNT_W'(h);
    retrig_en   = re;
    now      = cyc;
    busy_now = (now >= m_acc + 1) && (now <= m_be);
    act_now  = (now >= m_ps) && (now <= m_pe);
    missed   = 1'b0;
    if (!busy_now) begin
      if (t && w != 0) begin
        m_acc = now;
        m_ps  = now + 1 + d;
        m_pe  = now + d + w;
        m_be  = m_pe + h;
        m_h   = h;
      end
    end else if (t) begin
      if (act_now && re && w != 0) begin
        m_pe = now + w;
        m_be = m_pe + m_h;
      end else begin
        missed = 1'b1;
      end
    end
    e.cyc    = now + 1;
    e.pulse  = (now + 1 >= m_ps) && (now + 1 <= m_pe);
    e.busy   = (now + 1 >= m_acc + 1) && (now + 1 <= m_be);
    e.missed = missed;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int w);
    for (int i = 0; i < n; i++) step(1'b0, 0, w, 0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("async_pulse", pulse_out, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_missed", trig_missed, 1'b0);
    q.delete();
    model_reset();
    trig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_pulse", pulse_out, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
  endtask

  // Monitor: compare each cycle's outputs with the scoreboard entry for it.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
    if (!rst && q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("pulse_out", pulse_out, e.pulse);
      chk("busy", busy, e.busy);
      chk("trig_missed", trig_missed, e.missed);
    end
  end

  initial begin
    rst = 1'b1; trig_in = 1'b0; delay_cfg = '0; width_cfg = '0;
    holdoff_cfg = '0; retrig_en = 1'b0;
    model_reset();
    #1;
    chk("reset_pulse", pulse_out, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_missed", trig_missed, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic pulse, then immediate re-acceptance.
    idle(9, 3);
    step(1'b1, 0, 3, 0, 1'b0);
    idle(3, 3);
    step(1'b1, 0, 3, 0, 1'b0);
    idle(6, 3);

    // Delay and holdoff, trigger in final holdoff cycle then just after.
    step(1'b1, 4, 2, 5, 1'b0);
    idle(10, 2);
    step(1'b1, 4, 2, 5, 1'b0);
    step(1'b1, 4, 2, 5, 1'b0);
    idle(14, 2);

    // Retrigger enabled and disabled.
    step(1'b1, 0, 4, 0, 1'b1);
    idle(2, 4);
    step(1'b1, 0, 4, 0, 1'b1);
    idle(10, 4);
    step(1'b1, 0, 4, 0, 1'b0);
    idle(2, 4);
    step(1'b1, 0, 4, 0, 1'b0);
    idle(6, 4);

    // Config capture: width changes after acceptance.
    step(1'b1, 0, 8, 0, 1'b0);
    step(1'b0, 0, 8, 0, 1'b0);
    idle(12, 2);

    // width_cfg == 0 in IDLE is silently ignored; retrigger with width 0 is a miss.
    step(1'b1, 0, 0, 0, 1'b0);
    idle(3, 0);
    step(1'b1, 0, 3, 0, 1'b1);
    step(1'b1, 0, 0, 0, 1'b1);
    idle(5, 0);

    // Reset mid-pulse, then a full pulse afterwards.
    step(1'b1, 0, 100, 0, 1'b0);
    idle(19, 100);
    do_reset();
    step(1'b1, 0, 5, 0, 1'b0);
    idle(8, 5);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)));
      end
    end
    idle(30, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
